// File: rtl/max_subtract_64_pkg.sv
// Shared widths, length-mode encodings and the saturating lane subtract for the
// max-subtract stage that feeds the softmax exponent approximation.
package max_subtract_64_pkg;

    localparam int DW    = 16;
    localparam int LANES = 64;

    localparam logic [3:0] LM_16 = 4'b0001;
    localparam logic [3:0] LM_32 = 4'b0010;
    localparam logic [3:0] LM_64 = 4'b0100;

    typedef struct packed {
        logic                 err;
        logic signed [DW-1:0] val;
    } sat_res_t;

    // x - m in DW+1 bits. A positive result means x exceeded its group max, which
    // the max tree can never legitimately produce: it is reported and clamped to 0.
    function automatic sat_res_t sat_sub16(input logic signed [DW-1:0] x,
                                           input logic signed [DW-1:0] m);
        logic     [DW:0] d;
        sat_res_t        r;
        d     = {x[DW-1], x} - {m[DW-1], m};
        r.err = ~d[DW] & (|d[DW-1:0]);
        if (r.err) begin
            r.val = '0;
        end else if (d[DW] & ~d[DW-1]) begin
            r.val = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r.val = d[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/max_subtract_64_if.sv
// Bus between max_tree_64 (data, mode, group maxima) and the exp stage (differences).
interface max_subtract_64_if;
    import max_subtract_64_pkg::*;

    logic                  i_en;
    logic [3:0]            i_length_mode;
    logic                  i_valid_max;
    logic [LANES*DW-1:0]   i_in_flat;
    logic [DW-1:0]         i_max64_0;
    logic [DW-1:0]         i_max32_0;
    logic [DW-1:0]         i_max32_1;
    logic [DW-1:0]         i_max16_0;
    logic [DW-1:0]         i_max16_1;
    logic [DW-1:0]         i_max16_2;
    logic [DW-1:0]         i_max16_3;
    logic                  o_valid;
    logic [LANES*DW-1:0]   o_sub_flat;
    logic [3:0]            o_length_mode_byp;
    logic                  o_err_sticky;

    modport slave (
        input  i_en, i_length_mode, i_valid_max, i_in_flat,
        input  i_max64_0, i_max32_0, i_max32_1,
        input  i_max16_0, i_max16_1, i_max16_2, i_max16_3,
        output o_valid, o_sub_flat, o_length_mode_byp, o_err_sticky
    );

    modport master (
        output i_en, i_length_mode, i_valid_max, i_in_flat,
        output i_max64_0, i_max32_0, i_max32_1,
        output i_max16_0, i_max16_1, i_max16_2, i_max16_3,
        input  o_valid, o_sub_flat, o_length_mode_byp, o_err_sticky
    );

endinterface

// File: rtl/max_subtract_64_sub_sat_lane.sv
// One lane of stage 2: saturating x - max and its output register, plus a
// combinational inconsistency flag qualified by stage-1 valid and enable.
module sub_sat_lane
    import max_subtract_64_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 en,
    input  logic                 vld_p1,
    input  logic signed [DW-1:0] x_p1,
    input  logic signed [DW-1:0] m_p1,
    output logic signed [DW-1:0] sub_p2,
    output logic                 err
);

    sat_res_t res_p1;

    always_comb begin
        res_p1 = sat_sub16(x_p1, m_p1);
    end

    assign err = en & vld_p1 & res_p1.err;

    // Stage 1 -> stage 2
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sub_p2 <= '0;
        end else if (en) begin
            sub_p2 <= res_p1.val;
        end
    end

endmodule

// File: rtl/max_subtract_64.sv
// Per-lane x - max(group) with int16 saturation, two enabled cycles of latency,
// placed between max_tree_64 and the exponent approximation.
module max_subtract_64
    import max_subtract_64_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    max_subtract_64_if.slave  bus
);

    logic                      is16;
    logic                      is32;
    logic                      mode_illegal;
    logic [3:0][DW-1:0]        max16;
    logic [1:0][DW-1:0]        max32;
    logic [LANES*DW-1:0]       m_sel_flat;

    logic [LANES*DW-1:0]       x_flat_p1;
    logic [LANES*DW-1:0]       m_flat_p1;
    logic [3:0]                mode_p1;
    logic                      vld_p1;

    logic [LANES*DW-1:0]       sub_flat_p2;
    logic [3:0]                mode_p2;
    logic                      vld_p2;
    logic [LANES-1:0]          lane_err;
    logic                      mode_err;
    logic                      err_sticky;

    assign is16         = (bus.i_length_mode == LM_16);
    assign is32         = (bus.i_length_mode == LM_32);
    assign mode_illegal = ~is16 & ~is32 & (bus.i_length_mode != LM_64);
    assign mode_err     = bus.i_en & bus.i_valid_max & mode_illegal;

    assign max16 = {bus.i_max16_3, bus.i_max16_2, bus.i_max16_1, bus.i_max16_0};
    assign max32 = {bus.i_max32_1, bus.i_max32_0};

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DW-1:0] m_sel;

        // Illegal modes fall through to the full-vector max.
        always_comb begin
            m_sel = bus.i_max64_0;
            if (is16) begin
                m_sel = max16[2'(l / 16)];
            end else if (is32) begin
                m_sel = max32[1'(l / 32)];
            end
        end

        assign m_sel_flat[l*DW +: DW] = m_sel;

        sub_sat_lane u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .en     (bus.i_en),
            .vld_p1 (vld_p1),
            .x_p1   (x_flat_p1[l*DW +: DW]),
            .m_p1   (m_flat_p1[l*DW +: DW]),
            .sub_p2 (sub_flat_p2[l*DW +: DW]),
            .err    (lane_err[l])
        );
    end

    // Input -> stage 1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_flat_p1 <= '0;
            m_flat_p1 <= '0;
            mode_p1   <= '0;
            vld_p1    <= 1'b0;
        end else if (bus.i_en) begin
            x_flat_p1 <= bus.i_in_flat;
            m_flat_p1 <= m_sel_flat;
            mode_p1   <= bus.i_length_mode;
            vld_p1    <= bus.i_valid_max;
        end
    end

    // Stage 1 -> stage 2
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_p2 <= '0;
            vld_p2  <= 1'b0;
        end else if (bus.i_en) begin
            mode_p2 <= mode_p1;
            vld_p2  <= vld_p1;
        end
    end

    // Lane flags are already enable- and valid-qualified.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= err_sticky | mode_err | (|lane_err);
        end
    end

    assign bus.o_valid           = vld_p2;
    assign bus.o_sub_flat        = sub_flat_p2;
    assign bus.o_length_mode_byp = mode_p2;
    assign bus.o_err_sticky      = err_sticky;

endmodule
